// File: rtl/uart_bridge_pkg.sv
// Shared command codes, state encodings and helpers for the UART-to-bus bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, WAIT, RESP} br_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/uart_bridge_phy.sv
// 8N1 UART receiver and transmitter used by the bridge frame engine.
module uart_bridge_phy
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1458
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_busy,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       tx_ready
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic        rx_meta_r;
  logic        rx_sync_r;
  logic        rx_prev_r;
  rx_state_t   rx_state_r;
  logic [15:0] rx_cnt_r;
  logic [2:0]  rx_bit_r;
  logic [7:0]  rx_shift_r;
  logic [7:0]  rx_byte_r;
  logic        rx_valid_r;
  logic        rx_ferr_r;

  logic        tx_r;
  logic        tx_ready_r;
  logic [15:0] tx_cnt_r;
  logic [3:0]  tx_bits_r;
  logic [8:0]  tx_shift_r;

  // Two-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receive state machine: start re-check at half bit, data and stop sampled mid-bit
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= 16'd0;
          rx_bit_r <= 3'd0;
          if (rx_prev_r && !rx_sync_r) rx_state_r <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_r == HALF_LAST) begin
            rx_cnt_r   <= 16'd0;
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= 16'd0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            rx_bit_r   <= rx_bit_r + 3'd1;
            if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= 16'd0;
            rx_state_r <= RX_IDLE;
            if (rx_sync_r) begin
              rx_byte_r  <= rx_shift_r;
              rx_valid_r <= 1'b1;
            end else begin
              rx_ferr_r <= 1'b1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Transmit shifter: start bit driven at load, then 8 data bits and the stop bit
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tx_r       <= 1'b1;
      tx_ready_r <= 1'b1;
      tx_cnt_r   <= 16'd0;
      tx_bits_r  <= 4'd0;
      tx_shift_r <= 9'h1FF;
    end else if (tx_ready_r) begin
      tx_cnt_r <= 16'd0;
      if (tx_start) begin
        tx_r       <= 1'b0;
        tx_shift_r <= {1'b1, tx_byte};
        tx_bits_r  <= 4'd9;
        tx_ready_r <= 1'b0;
      end
    end else if (tx_cnt_r == BIT_LAST) begin
      tx_cnt_r <= 16'd0;
      if (tx_bits_r == 4'd0) begin
        tx_ready_r <= 1'b1;
        tx_r       <= 1'b1;
      end else begin
        tx_r       <= tx_shift_r[0];
        tx_shift_r <= {1'b1, tx_shift_r[8:1]};
        tx_bits_r  <= tx_bits_r - 4'd1;
      end
    end else begin
      tx_cnt_r <= tx_cnt_r + 16'd1;
    end
  end

  assign TX       = tx_r;
  assign tx_ready = tx_ready_r;
  assign rx_byte  = rx_byte_r;
  assign rx_valid = rx_valid_r;
  assign rx_ferr  = rx_ferr_r;
  assign rx_busy  = (rx_state_r != RX_IDLE);

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command frames in, single 32-bit bus master transactions out, ack/data/error frame back.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 1458,
  parameter int BUS_TIMEOUT   = 1024,
  parameter int FRAME_TIMEOUT = 32
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        RX,
  output logic        TX,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_err,
  output logic        busy
);

  localparam int              BT_W       = $clog2(BUS_TIMEOUT) + 1;
  localparam logic [BT_W-1:0] BUS_LAST   = BT_W'(BUS_TIMEOUT - 1);
  localparam logic [23:0]     FRAME_LAST = 24'(FRAME_TIMEOUT * CLKS_PER_BIT - 1);

  logic [7:0]  rx_byte_s;
  logic        rx_valid_s;
  logic        rx_ferr_s;
  logic        rx_busy_s;
  logic        tx_ready_s;
  logic [31:0] next_addr_s;
  logic [31:0] next_wdata_s;
  logic [2:0]  rsp_len_s;
  logic        frame_expired_s;

  br_state_t       state_r;
  logic [1:0]      byte_cnt_r;
  logic            cmd_we_r;
  logic [31:0]     addr_r;
  logic [31:0]     wdata_r;
  logic [31:0]     rdata_r;
  logic            err_r;
  logic [2:0]      rsp_idx_r;
  logic [7:0]      tx_byte_r;
  logic            tx_start_r;
  logic [BT_W-1:0] bus_tmr_r;
  logic [23:0]     frame_tmr_r;
  logic            m_req_r;
  logic            m_we_r;
  logic [31:0]     m_addr_r;
  logic [3:0]      m_be_r;
  logic [31:0]     m_wdata_r;
  logic            busy_r;

  uart_bridge_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .RX       (RX),
    .TX       (TX),
    .rx_byte  (rx_byte_s),
    .rx_valid (rx_valid_s),
    .rx_ferr  (rx_ferr_s),
    .rx_busy  (rx_busy_s),
    .tx_byte  (tx_byte_r),
    .tx_start (tx_start_r),
    .tx_ready (tx_ready_s)
  );

  assign next_addr_s     = {addr_r[23:0], rx_byte_s};
  assign next_wdata_s    = {wdata_r[23:0], rx_byte_s};
  assign rsp_len_s       = (err_r || cmd_we_r) ? 3'd1 : 3'd5;
  assign frame_expired_s = (frame_tmr_r >= FRAME_LAST);

  // Inter-byte idle timer: held clear while a byte is on the wire, so only line idle time counts
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      frame_tmr_r <= 24'd0;
    end else if (rx_valid_s || rx_busy_s || !(state_r == ADDR || state_r == DATA)) begin
      frame_tmr_r <= 24'd0;
    end else if (frame_tmr_r != 24'hFF_FFFF) begin
      frame_tmr_r <= frame_tmr_r + 24'd1;
    end
  end

  // Frame engine, bus master registers and response sequencing
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r    <= IDLE;
      byte_cnt_r <= 2'd0;
      cmd_we_r   <= 1'b0;
      addr_r     <= 32'h0;
      wdata_r    <= 32'h0;
      rdata_r    <= 32'h0;
      err_r      <= 1'b0;
      rsp_idx_r  <= 3'd0;
      tx_byte_r  <= 8'h00;
      tx_start_r <= 1'b0;
      bus_tmr_r  <= '0;
      m_req_r    <= 1'b0;
      m_we_r     <= 1'b0;
      m_addr_r   <= 32'h0;
      m_be_r     <= 4'h0;
      m_wdata_r  <= 32'h0;
      busy_r     <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          bus_tmr_r <= '0;
          if (rx_valid_s && (rx_byte_s == CMD_WR || rx_byte_s == CMD_RD)) begin
            cmd_we_r   <= (rx_byte_s == CMD_WR);
            byte_cnt_r <= 2'd0;
            err_r      <= 1'b0;
            rsp_idx_r  <= 3'd0;
            state_r    <= ADDR;
            busy_r     <= 1'b1;
          end
        end
        ADDR: begin
          if (rx_ferr_s || frame_expired_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (rx_valid_s) begin
            addr_r     <= next_addr_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              if (cmd_we_r) begin
                state_r <= DATA;
              end else begin
                state_r   <= REQ;
                bus_tmr_r <= '0;
                m_req_r   <= 1'b1;
                m_we_r    <= 1'b0;
                m_addr_r  <= word_align(next_addr_s);
                m_be_r    <= 4'hF;
                m_wdata_r <= 32'h0;
              end
            end
          end
        end
        DATA: begin
          if (rx_ferr_s || frame_expired_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (rx_valid_s) begin
            wdata_r    <= next_wdata_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              state_r   <= REQ;
              bus_tmr_r <= '0;
              m_req_r   <= 1'b1;
              m_we_r    <= 1'b1;
              m_addr_r  <= word_align(addr_r);
              m_be_r    <= 4'hF;
              m_wdata_r <= next_wdata_s;
            end
          end
        end
        REQ: begin
          if (m_gnt) begin
            m_req_r   <= 1'b0;
            bus_tmr_r <= bus_tmr_r + 1'b1;
            if (m_rvalid) begin
              rdata_r <= m_rdata;
              err_r   <= m_err;
              state_r <= RESP;
            end else begin
              state_r <= WAIT;
            end
          end else if (bus_tmr_r >= BUS_LAST) begin
            m_req_r <= 1'b0;
            err_r   <= 1'b1;
            state_r <= RESP;
          end else begin
            bus_tmr_r <= bus_tmr_r + 1'b1;
          end
        end
        WAIT: begin
          if (m_rvalid) begin
            rdata_r <= m_rdata;
            err_r   <= m_err;
            state_r <= RESP;
          end else if (bus_tmr_r >= BUS_LAST) begin
            err_r   <= 1'b1;
            state_r <= RESP;
          end else begin
            bus_tmr_r <= bus_tmr_r + 1'b1;
          end
        end
        RESP: begin
          // tx_ready lags tx_start by one cycle, so skip the cycle right after a launch
          if (tx_ready_s && !tx_start_r) begin
            if (rsp_idx_r == rsp_len_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              tx_start_r <= 1'b1;
              rsp_idx_r  <= rsp_idx_r + 3'd1;
              if (rsp_idx_r == 3'd0) begin
                tx_byte_r <= err_r ? RSP_ERR : RSP_OK;
              end else begin
                tx_byte_r <= rdata_r[31:24];
                rdata_r   <= {rdata_r[23:0], 8'h00};
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
          m_req_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign m_req   = m_req_r;
  assign m_we    = m_we_r;
  assign m_addr  = m_addr_r;
  assign m_be    = m_be_r;
  assign m_wdata = m_wdata_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench: UART frame driver, TX decoder, bus slave and a frame-level reference model.
module tb_uart_bus_bridge;

  localparam int CPB = 8;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_gnt, m_rvalid, m_err;
  logic [31:0] m_rdata;
  logic        busy;

  int n_asserts = 0;
  int n_fail = 0;

  logic [7:0] tx_q[$];
  int         tx_bad = 0;
  bus_t       bus_q[$];
  int         req_rises = 0;
  int         req_hi = 0;
  logic       req_prev = 1'b0;

  int          sl_gd = 0;
  int          sl_rd = 1;
  logic [31:0] sl_rdata = 32'h0;
  logic        sl_err = 1'b0;
  logic        sl_never = 1'b0;

  uart_bus_bridge #(.CLKS_PER_BIT(CPB), .BUS_TIMEOUT(64), .FRAME_TIMEOUT(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RX(RX), .TX(TX),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge Clk);
    RX = 1'b0;
    repeat (CPB) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge Clk);
    end
    RX = stop_bit;
    repeat (CPB) @(negedge Clk);
    RX = 1'b1;
    repeat (CPB) @(negedge Clk);
  endtask

  task automatic send_frame(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(we ? 8'h57 : 8'h52, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8], 1'b1);
    if (we) for (int i = 3; i >= 0; i--) send_byte(wdata[i*8 +: 8], 1'b1);
  endtask

  task automatic clear_logs();
    tx_q.delete();
    bus_q.delete();
    req_rises = 0;
    req_hi = 0;
    tx_bad = 0;
  endtask

  // Waits for n response bytes and busy low, then lingers to catch stray bytes
  task automatic wait_idle(input int n);
    for (int c = 0; c < 4000; c++) begin
      @(negedge Clk);
      if (tx_q.size() >= n && busy === 1'b0) break;
    end
    repeat (3 * CPB * 10) @(negedge Clk);
  endtask

  task automatic chk_tx(input string tag, input logic [7:0] exp_q[$]);
    chk({tag, "_txcnt"}, 32'(tx_q.size()), 32'(exp_q.size()));
    chk({tag, "_txframe"}, 32'(tx_bad), 32'd0);
    foreach (exp_q[i])
      chk($sformatf("%s_tx%0d", tag, i),
          (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
  endtask

  // One full transaction checked against the frame-level model
  task automatic do_frame(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gd, input int rd, input logic err);
    logic [7:0] exp_q[$];
    sl_gd = gd; sl_rd = rd; sl_rdata = rdata; sl_err = err; sl_never = 1'b0;
    clear_logs();
    if (err) exp_q = '{8'h45};
    else if (we) exp_q = '{8'h4B};
    else exp_q = '{8'h4B, rdata[31:24], rdata[23:16], rdata[15:8], rdata[7:0]};
    send_frame(we, addr, wdata);
    wait_idle(exp_q.size());
    chk({tag, "_reqs"}, 32'(req_rises), 32'd1);
    chk({tag, "_busq"}, 32'(bus_q.size()), 32'd1);
    if (bus_q.size() == 1) begin
      chk({tag, "_we"}, {31'h0, bus_q[0].we}, {31'h0, we});
      chk({tag, "_addr"}, bus_q[0].addr, {addr[31:2], 2'b00});
      chk({tag, "_be"}, {28'h0, bus_q[0].be}, 32'hF);
      if (we) chk({tag, "_wdata"}, bus_q[0].wdata, wdata);
    end
    chk_tx(tag, exp_q);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  // TX line decoder
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge Clk);
      if (TX === 1'b0) begin
        repeat (CPB / 2) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge Clk);
          b[i] = TX;
        end
        repeat (CPB) @(negedge Clk);
        if (TX === 1'b1) tx_q.push_back(b);
        else tx_bad++;
      end
    end
  end

  // m_req edge and level monitor
  initial begin
    forever begin
      @(negedge Clk);
      if (m_req === 1'b1) begin
        req_hi++;
        if (!req_prev) req_rises++;
      end
      req_prev = (m_req === 1'b1);
    end
  end

  // Bus slave
  initial begin
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
    forever begin
      @(posedge Clk); #1;
      if (m_req === 1'b1 && !sl_never) begin
        repeat (sl_gd) begin @(posedge Clk); #1; end
        bus_q.push_back('{we: m_we, be: m_be, addr: m_addr, wdata: m_wdata});
        m_gnt = 1'b1;
        if (sl_rd == 0) begin m_rvalid = 1'b1; m_rdata = sl_rdata; m_err = sl_err; end
        @(posedge Clk); #1;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_err = 1'b0;
        if (sl_rd != 0) begin
          repeat (sl_rd - 1) begin @(posedge Clk); #1; end
          m_rvalid = 1'b1; m_rdata = sl_rdata; m_err = sl_err;
          @(posedge Clk); #1;
          m_rvalid = 1'b0; m_err = 1'b0;
        end
      end
    end
  end

  initial begin
    logic       reached;
    logic [7:0] exp_q[$];
    repeat (3) @(negedge Clk);
    chk("rst_tx", {31'h0, TX}, 32'h1);
    chk("rst_req", {31'h0, m_req}, 32'h0);
    chk("rst_we", {31'h0, m_we}, 32'h0);
    chk("rst_addr", m_addr, 32'h0);
    chk("rst_be", {28'h0, m_be}, 32'h0);
    chk("rst_wdata", m_wdata, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);

    do_frame("wr", 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 1, 1'b0);
    do_frame("rd", 1'b0, 32'h0000_1004, 32'h0, 32'h1234_5678, 0, 3, 1'b0);

    // Non-command byte must be ignored
    clear_logs();
    send_byte(8'h33, 1'b1);
    repeat (60) @(negedge Clk);
    chk("ign_busy", {31'h0, busy}, 32'h0);
    chk("ign_tx", 32'(tx_q.size()), 32'd0);
    do_frame("ign_rd", 1'b0, $urandom, 32'h0, $urandom, 1, 2, 1'b0);

    // Bus timeout with no grant
    clear_logs();
    sl_never = 1'b1;
    send_frame(1'b0, 32'h0000_2000, 32'h0);
    wait_idle(1);
    chk("to_req_cycles", 32'(req_hi), 32'd64);
    chk("to_req_low", {31'h0, m_req}, 32'h0);
    chk("to_busq", 32'(bus_q.size()), 32'd0);
    exp_q = '{8'h45};
    chk_tx("to", exp_q);
    chk("to_busy", {31'h0, busy}, 32'h0);
    sl_never = 1'b0;

    // Framing error mid-frame
    clear_logs();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'($urandom), 1'b0);
    repeat (100) @(negedge Clk);
    chk("ferr_reqs", 32'(req_rises), 32'd0);
    chk("ferr_tx", 32'(tx_q.size()), 32'd0);
    chk("ferr_busy", {31'h0, busy}, 32'h0);
    do_frame("ferr_next", 1'b1, $urandom, $urandom, 32'h0, 0, 1, 1'b0);

    // Partial frame abandoned after the idle limit
    clear_logs();
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (100) @(negedge Clk);
    chk("ftmo_busy", {31'h0, busy}, 32'h0);
    chk("ftmo_reqs", 32'(req_rises), 32'd0);
    chk("ftmo_tx", 32'(tx_q.size()), 32'd0);

    // Asynchronous reset while waiting on the bus
    clear_logs();
    sl_gd = 0; sl_rd = 40; sl_rdata = 32'hCAFE_F00D; sl_err = 1'b0;
    send_frame(1'b0, 32'h0000_3000, 32'h0);
    reached = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge Clk);
      if (bus_q.size() == 1 && m_req === 1'b0 && busy === 1'b1) begin
        reached = 1'b1;
        break;
      end
    end
    chk("arst_wait_reached", {31'h0, reached}, 32'h1);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_tx", {31'h0, TX}, 32'h1);
    chk("arst_req", {31'h0, m_req}, 32'h0);
    chk("arst_we", {31'h0, m_we}, 32'h0);
    chk("arst_addr", m_addr, 32'h0);
    chk("arst_be", {28'h0, m_be}, 32'h0);
    chk("arst_wdata", m_wdata, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (80) @(negedge Clk);
    chk("arst_no_tx", 32'(tx_q.size()), 32'd0);
    do_frame("arst_next", 1'b0, $urandom, 32'h0, $urandom, 0, 1, 1'b0);

    // Randomized transactions, including same-cycle gnt/rvalid and bus errors
    for (int k = 0; k < 8; k++) begin
      logic we;
      we = 1'($urandom_range(0, 1));
      do_frame($sformatf("rnd%0d", k), we, $urandom, $urandom, $urandom,
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
               ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
